pid_sample_sequencer: RTL and testbench

//  Sequences one PID sample: period timer tick -> PV SPI read -> PID compute strobe -> output-valid strobe.

---
 rtl/pid_pkg.sv | 11 +
 rtl/pid_period_timer.sv | 15 +
 rtl/pid_sample_sequencer.sv | 97 +++++++++
 tb/tb_pid_sample_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// pid_pkg: sequencer state encodings and config word field offsets shared with the top level
package pid_pkg;
  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_READ = 2'd1;
  localparam logic [1:0] SEQ_COMPUTE = 2'd2;
  localparam int CFG_SP_OFF = 20;
  localparam int CFG_KP_OFF = 15;
  localparam int CFG_KI_OFF = 10;
  localparam int CFG_KD_OFF = 5;
  localparam int CFG_PER_OFF = 0;
endpackage

// File: rtl/pid_period_timer.sv
// pid_period_timer: reloadable down-counter, ticks when it reaches zero and reloads on that edge
module pid_period_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] period,
  output logic         tick
);
  logic [W-1:0] count;
  assign tick = count == '0;
  // count down, reload period on tick or reset
  always_ff @(posedge clk)
    count <= (reset || tick) ? period : count - 1'b1;
endmodule

// File: rtl/pid_sample_sequencer.sv
// pid_sample_sequencer: tick -> PV read -> PID strobe -> output strobe, with double-buffered config (PID_SEQ_TIMEOUT_EN adds a READ abort)
module pid_sample_sequencer
  import pid_pkg::*;
#(
  parameter int PERIOD_BITS = 12,
  parameter int CFG_BITS = 28,
  parameter logic [CFG_BITS-1:0] CFG_RESET = 28'h0,
  parameter int PID_LAT = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [CFG_BITS-1:0]    cfg_in,
  input  logic                   cfg_valid,
  output logic [CFG_BITS-1:0]    cfg_active,
  output logic                   pv_start,
  input  logic                   pv_done,
  output logic                   pid_stb,
  output logic                   out_stb,
  output logic                   overrun,
  output logic                   timeout,
  output logic [1:0]             seq_state
);
  localparam int LW = $clog2(PID_LAT + 1);
  logic tick;
  logic expire;
  logic [1:0] state;
  logic [LW-1:0] lat;
  logic [CFG_BITS-1:0] pending;
  logic pend_flag;
  pid_period_timer #(.W(PERIOD_BITS)) u_timer (.clk, .reset, .period, .tick);
  assign seq_state = state;
`ifdef PID_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] rd_cnt;
  assign expire = state == SEQ_READ && !pv_done && rd_cnt == TW'(TIMEOUT - 1);
  // count READ cycles; a read that never completes raises the sticky timeout
  always_ff @(posedge clk)
    if (reset) begin
      rd_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      rd_cnt <= state == SEQ_READ ? rd_cnt + 1'b1 : '0;
      if (expire) timeout <= 1'b1;
    end
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  // sequencer FSM, pulse generation and config shadow commit at the sample boundary
  always_ff @(posedge clk)
    if (reset) begin
      state <= SEQ_IDLE;
      pv_start <= 1'b0;
      pid_stb <= 1'b0;
      out_stb <= 1'b0;
      overrun <= 1'b0;
      cfg_active <= CFG_RESET;
      pending <= CFG_RESET;
      pend_flag <= 1'b0;
      lat <= '0;
    end else begin
      pv_start <= 1'b0;
      pid_stb <= 1'b0;
      out_stb <= 1'b0;
      if (cfg_valid) begin
        pending <= cfg_in;
        pend_flag <= 1'b1;
      end
      if (tick && state != SEQ_IDLE) overrun <= 1'b1;
      case (state)
        SEQ_IDLE:
          if (tick) begin
            state <= SEQ_READ;
            pv_start <= 1'b1;
            if (cfg_valid || pend_flag) begin
              cfg_active <= cfg_valid ? cfg_in : pending;
              pend_flag <= 1'b0;
            end
          end
        SEQ_READ:
          if (pv_done) begin
            state <= SEQ_COMPUTE;
            pid_stb <= 1'b1;
            lat <= LW'(PID_LAT);
          end else if (expire) state <= SEQ_IDLE;
        default: begin
          lat <= lat - 1'b1;
          if (lat == LW'(1)) begin
            state <= SEQ_IDLE;
            out_stb <= 1'b1;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_pid_sample_sequencer.sv
// tb_pid_sample_sequencer: random stimulus against an event-time model of the sample sequence
module tb_pid_sample_sequencer;
  localparam int PB = 12, CB = 28, PL = 2, TO = 16;
  localparam logic [CB-1:0] CR = 28'h0;
  logic clk = 0, reset = 1, cfg_valid = 0, pv_done = 0;
  logic [PB-1:0] period = 0;
  logic [CB-1:0] cfg_in = 0, cfg_active;
  logic pv_start, pid_stb, out_stb, overrun, timeout;
  logic [1:0] seq_state;
  int errors = 0, checks = 0;
  int c, t_start, r, out_at;
  bit seq, m_over, m_to, pflag;
  logic [CB-1:0] m_act, pend;

  pid_sample_sequencer #(.PERIOD_BITS(PB), .CFG_BITS(CB), .CFG_RESET(CR), .PID_LAT(PL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .period(period), .cfg_in(cfg_in), .cfg_valid(cfg_valid),
    .cfg_active(cfg_active), .pv_start(pv_start), .pv_done(pv_done), .pid_stb(pid_stb),
    .out_stb(out_stb), .overrun(overrun), .timeout(timeout), .seq_state(seq_state));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, c);
    end
  endtask

  task automatic do_reset(input logic [PB-1:0] p);
    period = p;
    reset = 1;
    cfg_valid = 0;
    pv_done = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    c = 0;
    seq = 0;
    t_start = -1;
    r = -1;
    out_at = -1;
    m_over = 0;
    m_to = 0;
    pflag = 0;
    m_act = CR;
    pend = CR;
  endtask

  function automatic bit reading();
    return seq && r < 0 && c >= t_start;
  endfunction

  function automatic bit computing();
    return seq && r >= 0 && c > r && c <= r + PL;
  endfunction

  // check cycle c outputs, then apply cycle c inputs to the model and advance
  task automatic step(input bit dn, input bit cv, input logic [CB-1:0] ci);
    bit busy, tk;
    if (seq && r >= 0 && c > r + PL) seq = 0;
    chk("seq_state", seq_state, !seq ? 0 : (r < 0 ? 1 : 2));
    chk("pv_start", pv_start, seq && c == t_start);
    chk("pid_stb", pid_stb, seq && r >= 0 && c == r + 1);
    chk("out_stb", out_stb, c == out_at);
    chk("overrun", overrun, m_over);
    chk("timeout", timeout, m_to);
    chk("cfg_active", cfg_active, m_act);
    pv_done = dn;
    cfg_valid = cv;
    cfg_in = ci;
    busy = seq;
    tk = (c % (int'(period) + 1)) == int'(period);
    if (cv) begin
      pend = ci;
      pflag = 1;
    end
    if (reading() && dn) begin
      r = c;
      out_at = c + 1 + PL;
    end
`ifdef PID_SEQ_TIMEOUT_EN
    else if (reading() && c - t_start == TO - 1) begin
      m_to = 1;
      seq = 0;
    end
`endif
    if (tk) begin
      if (busy) m_over = 1;
      else begin
        seq = 1;
        t_start = c + 1;
        r = -1;
        if (pflag) begin
          m_act = pend;
          pflag = 0;
        end
      end
    end
    @(posedge clk);
    #1 c++;
  endtask

  // fixed_d >= 0: pv_done exactly fixed_d cycles after pv_start; else random with rand_pct
  task automatic run(input int n, input int fixed_d, input int rand_pct, input int cv_pct);
    for (int i = 0; i < n; i++) begin
      bit dn;
      if (reading()) dn = fixed_d >= 0 ? c == t_start + fixed_d : $urandom_range(0, 99) < rand_pct;
      else dn = $urandom_range(0, 99) < 10;
      step(dn, $urandom_range(0, 99) < cv_pct, CB'($urandom));
    end
  endtask

  initial begin
    do_reset(9);
    run(60, 3, 0, 0);
    run(80, 3, 0, 30);
    do_reset(2);
    run(40, 5, 0, 20);
    do_reset(0);
    run(60, -1, 50, 40);
    do_reset(PB'($urandom_range(1, 15)));
    run(300, -1, 20, 10);
`ifdef PID_SEQ_TIMEOUT_EN
    do_reset(40);
    run(120, -1, 0, 0);
`endif
    do_reset(3);
    run(30, 1, 0, 100);
    for (int i = 0; i < 50 && !computing(); i++) step(reading() && c == t_start, 0, '0);
    chk("reached_compute", seq_state, 2);
    reset = 1;
    @(posedge clk);
    #1;
    chk("rst_pv_start", pv_start, 0);
    chk("rst_pid_stb", pid_stb, 0);
    chk("rst_out_stb", out_stb, 0);
    chk("rst_state", seq_state, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cfg_active", cfg_active, CR);
    reset = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
